p405s_dcdinstenc: RTL and testbench

- Instruction encoder and issuer: converts a compact command (operation code plus operand fields) into a 32-bit PowerPC instruction word and presents it to the decode stage through a valid/hold handshake.
- Produces exactly the primary/secondary opcode patterns that the decode instruction PLA recognises.
- Used by the debug instruction-stuff path and by the self-test sequencer.
- Contains a command FIFO, an encode register and an issue state machine.

---
 rtl/p405s_dcdinstenc.sv | 234 +++++++++++++++++++++++
 tb/tb_p405s_dcdinstenc.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p405s_dcdinstenc.sv
// p405s_dcdinstenc: instruction encoder and issuer.
// Compact commands are queued in a small FIFO. Each command is encoded into a
// 32-bit PowerPC instruction word and offered to decode via instValid/instHold.
// Optional feature macro: P405S_DCD_ENC_AUTOSYNC_EN. When it is defined, an isync
// word follows every accepted mtspr/mtcrf word.
module p405s_dcdinstenc #(
  parameter int DEPTH = 2
) (
  input  logic        CB,
  input  logic        resetN,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [4:0]  cmdOp,
  input  logic [4:0]  cmdRt,
  input  logic [4:0]  cmdRa,
  input  logic [4:0]  cmdRb,
  input  logic [23:0] cmdImm,
  input  logic        cmdAa,
  input  logic        cmdLk,
  input  logic        flush,
  input  logic        instHold,
  output logic        instValid,
  output logic [31:0] instData,
  output logic        instErr,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
  localparam logic [31:0] ISYNC_WORD = 32'h4C00012C;
`endif

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rt;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [23:0] imm;
    logic        aa;
    logic        lk;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
    ,ST_SYNC = 2'd2
`endif
  } state_t;

  // Returns {legal, word}; fields not used by an operation stay zero.
  function automatic logic [32:0] encode_cmd(input cmd_t c);
    logic [31:0] w;
    logic        legal;
    w     = '0;
    legal = 1'b1;
    case (c.op)
      5'd0:  w = {6'd31, c.rt, c.imm[4:0], c.imm[9:5], 10'd467, 1'b0};
      5'd1:  w = {6'd31, c.rt, c.imm[4:0], c.imm[9:5], 10'd339, 1'b0};
      5'd2:  w = {6'd19, c.rt[4:2], 2'b00, c.ra[4:2], 2'b00, 5'd0, 10'd0, 1'b0};
      5'd3:  w = {6'd31, c.rt[4:2], 2'b00, 5'd0, 5'd0, 10'd512, 1'b0};
      5'd4:  w = {6'd31, c.rt, 1'b0, c.imm[7:0], 1'b0, 10'd144, 1'b0};
      5'd5:  w = {6'd19, c.rt, c.ra, c.rb, 10'd257, 1'b0};
      5'd6:  w = {6'd19, c.rt, c.ra, c.rb, 10'd449, 1'b0};
      5'd7:  w = {6'd19, c.rt, c.ra, c.rb, 10'd193, 1'b0};
      5'd8:  w = {6'd18, c.imm, c.aa, c.lk};
      5'd9:  w = {6'd16, c.rt, c.ra, c.imm[13:0], c.aa, c.lk};
      5'd10: w = {6'd17, 24'd0, 1'b1, 1'b0};
      5'd11: w = {6'd19, 15'd0, 10'd50, 1'b0};
      5'd12: w = {6'd19, 15'd0, 10'd51, 1'b0};
      5'd13: w = {6'd19, 15'd0, 10'd150, 1'b0};
      5'd14: w = {6'd31, c.rt, c.ra, c.rb, 10'd150, 1'b1};
      5'd15: w = {6'd31, c.rt, c.ra, c.rb, 10'd914, 1'b0};
      default: legal = 1'b0;
    endcase
    return {legal, w};
  endfunction

  cmd_t        mem_q [DEPTH];
  cmd_t        mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t      state_q, state_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic        inst_valid_q, inst_valid_d;
  logic        inst_err_q, inst_err_d;
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
  logic        sync_pend_q, sync_pend_d;
`endif

  cmd_t        cmd_in, head;
  logic [32:0] head_enc;
  logic        fifo_empty, fifo_full, push, pop, try_pop, accept;

  assign cmd_in     = '{op: cmdOp, rt: cmdRt, ra: cmdRa, rb: cmdRb,
                        imm: cmdImm, aa: cmdAa, lk: cmdLk};
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = cmdValid & ~fifo_full & ~flush;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign head_enc   = encode_cmd(head);
  assign accept     = inst_valid_q & ~instHold;

  assign cmdReady  = ~fifo_full;
  assign instValid = inst_valid_q;
  assign instData  = inst_data_q;
  assign instErr   = inst_err_q;
  assign busy      = ~fifo_empty | inst_valid_q | (state_q != ST_IDLE);

  // Issue FSM: decide when to pop the FIFO head and what the output register holds next.
  always_comb begin
    state_d      = state_q;
    inst_data_d  = inst_data_q;
    inst_valid_d = inst_valid_q;
    inst_err_d   = 1'b0;
    try_pop      = 1'b0;
    pop          = 1'b0;
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
    sync_pend_d  = sync_pend_q;
`endif
    case (state_q)
      ST_IDLE: try_pop = ~fifo_empty & (~inst_valid_q | ~instHold);
      ST_ISSUE: begin
        if (accept) begin
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
          if (sync_pend_q) begin
            inst_data_d = ISYNC_WORD;
            sync_pend_d = 1'b0;
            state_d     = ST_SYNC;
          end else if (!fifo_empty) begin
            try_pop = 1'b1;
          end else begin
            inst_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end
`else
          if (!fifo_empty) begin
            try_pop = 1'b1;
          end else begin
            inst_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end
`endif
        end
      end
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
      ST_SYNC: begin
        if (accept) begin
          if (!fifo_empty) begin
            try_pop = 1'b1;
          end else begin
            inst_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (try_pop) begin
      pop = 1'b1;
      if (head_enc[32]) begin
        inst_data_d  = head_enc[31:0];
        inst_valid_d = 1'b1;
        state_d      = ST_ISSUE;
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
        sync_pend_d  = (head.op == 5'd0) || (head.op == 5'd4);
`endif
      end else begin
        inst_err_d   = 1'b1;
        inst_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    end

    if (flush) begin
      state_d      = ST_IDLE;
      inst_valid_d = 1'b0;
      inst_err_d   = 1'b0;
      pop          = 1'b0;
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
      sync_pend_d  = 1'b0;
`endif
    end
  end

  // FIFO next state: write at the tail on push, advance the head on pop, clear on flush.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = cmd_in;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CB or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= ST_IDLE;
      inst_data_q  <= '0;
      inst_valid_q <= 1'b0;
      inst_err_q   <= 1'b0;
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
      sync_pend_q  <= 1'b0;
`endif
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      inst_data_q  <= inst_data_d;
      inst_valid_q <= inst_valid_d;
      inst_err_q   <= inst_err_d;
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
      sync_pend_q  <= sync_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_p405s_dcdinstenc.sv
// Testbench for p405s_dcdinstenc: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_p405s_dcdinstenc;

  localparam int DEPTH = 2;
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
  localparam bit AUTOSYNC = 1'b1;
`else
  localparam bit AUTOSYNC = 1'b0;
`endif
  localparam logic [31:0] ISYNC = 32'h4C00012C;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rt;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [23:0] imm;
    logic        aa;
    logic        lk;
  } tcmd_t;

  logic        CB, resetN, cmdValid, cmdReady, cmdAa, cmdLk, flush, instHold;
  logic        instValid, instErr, busy;
  logic [4:0]  cmdOp, cmdRt, cmdRa, cmdRb;
  logic [23:0] cmdImm;
  logic [31:0] instData;

  int total = 0;
  int bad = 0;

  tcmd_t       mq[$];
  logic        m_valid, m_err, m_sync;
  logic [31:0] m_word;

  p405s_dcdinstenc #(.DEPTH(DEPTH)) dut (
    .CB(CB), .resetN(resetN), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdRt(cmdRt), .cmdRa(cmdRa), .cmdRb(cmdRb),
    .cmdImm(cmdImm), .cmdAa(cmdAa), .cmdLk(cmdLk), .flush(flush),
    .instHold(instHold), .instValid(instValid), .instData(instData),
    .instErr(instErr), .busy(busy)
  );

  initial CB = 1'b0;
  always #5 CB = ~CB;

  function automatic tcmd_t mk(int op, int rt, int ra, int rb, int imm, int aa, int lk);
    tcmd_t c;
    c.op = op[4:0]; c.rt = rt[4:0]; c.ra = ra[4:0]; c.rb = rb[4:0];
    c.imm = imm[23:0]; c.aa = aa[0]; c.lk = lk[0];
    return c;
  endfunction

  // Reference encoding built from primary/XO values and field placement rules.
  function automatic logic [32:0] ref_encode(tcmd_t c);
    int unsigned prim, xo, a, b, f3, rc, extra, imm, w;
    bit legal;
    a = c.rt; b = c.ra; f3 = c.rb; rc = 0; extra = 0; imm = c.imm;
    prim = 0; xo = 0; legal = 1;
    case (c.op)
      0:  begin prim = 31; xo = 467; b = imm % 32; f3 = (imm / 32) % 32; end
      1:  begin prim = 31; xo = 339; b = imm % 32; f3 = (imm / 32) % 32; end
      2:  begin prim = 19; xo = 0; a = (a / 4) * 4; b = (b / 4) * 4; f3 = 0; end
      3:  begin prim = 31; xo = 512; a = (a / 4) * 4; b = 0; f3 = 0; end
      4:  begin prim = 31; xo = 144; b = 0; f3 = 0; extra = (imm % 256) * 4096; end
      5:  begin prim = 19; xo = 257; end
      6:  begin prim = 19; xo = 449; end
      7:  begin prim = 19; xo = 193; end
      11: begin prim = 19; xo = 50;  a = 0; b = 0; f3 = 0; end
      12: begin prim = 19; xo = 51;  a = 0; b = 0; f3 = 0; end
      13: begin prim = 19; xo = 150; a = 0; b = 0; f3 = 0; end
      14: begin prim = 31; xo = 150; rc = 1; end
      15: begin prim = 31; xo = 914; end
      8, 9, 10: ;
      default: legal = 0;
    endcase
    if (c.op == 8)
      w = (18 << 26) | (imm << 2) | (int'(c.aa) << 1) | int'(c.lk);
    else if (c.op == 9)
      w = (16 << 26) | (a << 21) | (b << 16) | ((imm % 16384) << 2) | (int'(c.aa) << 1) | int'(c.lk);
    else if (c.op == 10)
      w = (17 << 26) | 2;
    else if (legal)
      w = (prim << 26) | (a << 21) | (b << 16) | (f3 << 11) | (xo << 1) | rc | extra;
    else
      w = 0;
    return {legal, w};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 0; m_err = 0; m_sync = 0; m_word = '0;
  endtask

  // One clock of the reference model, using the inputs present at the edge.
  task automatic model_update();
    int start_size;
    bit accepted;
    tcmd_t c;
    logic [32:0] e;
    start_size = mq.size();
    if (flush) begin
      model_reset();
      return;
    end
    m_err = 0;
    accepted = m_valid && !instHold;
    if (!m_valid || accepted) begin
      if (AUTOSYNC && accepted && m_sync) begin
        m_word = ISYNC;
        m_sync = 0;
      end else if (mq.size() > 0) begin
        c = mq.pop_front();
        e = ref_encode(c);
        if (e[32]) begin
          m_word = e[31:0]; m_valid = 1;
          m_sync = AUTOSYNC && (c.op == 0 || c.op == 4);
        end else begin
          m_err = 1; m_valid = 0;
        end
      end else begin
        m_valid = 0;
      end
    end
    if (cmdValid && start_size < DEPTH)
      mq.push_back('{op: cmdOp, rt: cmdRt, ra: cmdRa, rb: cmdRb, imm: cmdImm, aa: cmdAa, lk: cmdLk});
  endtask

  task automatic drive(tcmd_t c, bit v);
    cmdOp = c.op; cmdRt = c.rt; cmdRa = c.ra; cmdRb = c.rb;
    cmdImm = c.imm; cmdAa = c.aa; cmdLk = c.lk; cmdValid = v;
  endtask

  task automatic tick();
    @(posedge CB);
    model_update();
    @(negedge CB);
  endtask

  task automatic test_reset();
    resetN = 0;
    repeat (2) @(negedge CB);
    model_reset();
    total++; if (cmdReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", cmdReady); end
    total++; if (instValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", instValid); end
    total++; if (instData !== 32'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", instData); end
    total++; if (instErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", instErr); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    resetN = 1;
    @(negedge CB);
  endtask

  task automatic test_mtspr_latency();
    drive(mk(0, 3, 0, 0, 'h110, 0, 0), 1);
    tick();
    cmdValid = 0;
    total++; if (instValid !== 1'b0) begin bad++; $display("[TB] FAIL lat_n1_valid: got %b want 0", instValid); end
    tick();
    total++; if (instValid !== 1'b1) begin bad++; $display("[TB] FAIL lat_n2_valid: got %b want 1", instValid); end
    total++; if (instData !== 32'h7C7043A6) begin bad++; $display("[TB] FAIL lat_n2_data: got %h want 7c7043a6", instData); end
    tick();
    total++; if (busy !== 1'b0 || instValid !== 1'b0) begin bad++; $display("[TB] FAIL lat_drain: got busy=%b valid=%b want 0 0", busy, instValid); end
  endtask

  task automatic test_back_to_back();
    tcmd_t cmds[3];
    logic [31:0] exp[3];
    int idx, first;
    cmds[0] = mk(5, 1, 2, 3, 0, 0, 0);
    cmds[1] = mk(6, 4, 5, 6, 0, 0, 0);
    cmds[2] = mk(8, 0, 0, 0, 'h40, 0, 1);
    exp[0] = 32'h4C221A02; exp[1] = 32'h4C853382; exp[2] = 32'h48000101;
    idx = 0; first = -1;
    instHold = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 3) drive(cmds[cyc], 1); else cmdValid = 0;
      tick();
      if (instValid === 1'b1) begin
        if (first < 0) first = cyc;
        if (idx < 3) begin
          total++; if (instData !== exp[idx]) begin bad++; $display("[TB] FAIL b2b_word%0d: got %h want %h", idx, instData, exp[idx]); end
          total++; if (cyc != first + idx) begin bad++; $display("[TB] FAIL b2b_gap%0d: got cycle %0d want %0d", idx, cyc, first + idx); end
        end
        idx++;
      end
    end
    total++; if (idx != 3) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 3", idx); end
  endtask

  task automatic test_fill_hold();
    tcmd_t cmds[DEPTH+2];
    logic [32:0] e;
    for (int k = 0; k < DEPTH + 2; k++)
      cmds[k] = mk($urandom_range(5, 15), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    instHold = 1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      total++; if (cmdReady !== (k < DEPTH + 1)) begin bad++; $display("[TB] FAIL fill_ready%0d: got %b want %b", k, cmdReady, (k < DEPTH + 1)); end
      if (k >= 2) begin
        e = ref_encode(cmds[0]);
        total++; if (instValid !== 1'b1 || instData !== e[31:0]) begin bad++; $display("[TB] FAIL fill_hold%0d: got %b/%h want 1/%h", k, instValid, instData, e[31:0]); end
      end
      drive(cmds[k], 1);
      tick();
    end
    cmdValid = 0;
    repeat (3) tick();
    e = ref_encode(cmds[0]);
    total++; if (instValid !== 1'b1 || instData !== e[31:0]) begin bad++; $display("[TB] FAIL fill_stable: got %b/%h want 1/%h", instValid, instData, e[31:0]); end
    instHold = 0;
    for (int j = 1; j <= DEPTH; j++) begin
      tick();
      e = ref_encode(cmds[j]);
      total++; if (instValid !== 1'b1 || instData !== e[31:0]) begin bad++; $display("[TB] FAIL drain%0d: got %b/%h want 1/%h", j, instValid, instData, e[31:0]); end
    end
    tick();
    total++; if (instValid !== 1'b0) begin bad++; $display("[TB] FAIL drain_end: got %b want 0", instValid); end
  endtask

  task automatic test_illegal();
    instHold = 0;
    drive(mk(20, 1, 1, 1, 0, 0, 0), 1);
    tick();
    drive(mk(10, 0, 0, 0, 0, 0, 0), 1);
    tick();
    cmdValid = 0;
    total++; if (instErr !== 1'b1 || instValid !== 1'b0) begin bad++; $display("[TB] FAIL illegal_err: got err=%b valid=%b want 1 0", instErr, instValid); end
    tick();
    total++; if (instErr !== 1'b0) begin bad++; $display("[TB] FAIL illegal_pulse: got %b want 0", instErr); end
    total++; if (instValid !== 1'b1 || instData !== 32'h44000002) begin bad++; $display("[TB] FAIL sc_word: got %b/%h want 1/44000002", instValid, instData); end
    tick();
  endtask

  task automatic test_flush();
    instHold = 1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      drive(mk(k + 5, k, k, k, 0, 0, 0), 1);
      tick();
    end
    cmdValid = 0;
    total++; if (instValid !== 1'b1 || cmdReady !== 1'b0) begin bad++; $display("[TB] FAIL flush_pre: got valid=%b ready=%b want 1 0", instValid, cmdReady); end
    flush = 1;
    tick();
    flush = 0;
    total++; if (instValid !== 1'b0 || busy !== 1'b0 || cmdReady !== 1'b1) begin bad++; $display("[TB] FAIL flush_post: got valid=%b busy=%b ready=%b want 0 0 1", instValid, busy, cmdReady); end
    instHold = 0;
    drive(mk(6, 1, 1, 1, 0, 0, 0), 1);
    flush = 1;
    tick();
    flush = 0; cmdValid = 0;
    tick();
    total++; if (instValid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_drop: got valid=%b busy=%b want 0 0", instValid, busy); end
  endtask

  task automatic test_async_reset();
    instHold = 0;
    drive(mk(7, 2, 3, 4, 0, 0, 0), 1);
    tick();
    cmdValid = 0;
    tick();
    #2 resetN = 0;
    #1;
    total++; if (instValid !== 1'b0 || busy !== 1'b0 || cmdReady !== 1'b1 || instData !== 32'h0) begin bad++; $display("[TB] FAIL async_reset: got valid=%b busy=%b ready=%b data=%h want 0 0 1 0", instValid, busy, cmdReady, instData); end
    @(negedge CB);
    resetN = 1;
    model_reset();
    @(negedge CB);
  endtask

`ifdef P405S_DCD_ENC_AUTOSYNC_EN
  task automatic test_autosync();
    tcmd_t cmds[2];
    logic [31:0] exp[3];
    int idx, first;
    cmds[0] = mk(0, 3, 0, 0, 'h110, 0, 0);
    cmds[1] = mk(14, 1, 2, 3, 0, 0, 0);
    exp[0] = 32'h7C7043A6; exp[1] = 32'h4C00012C; exp[2] = 32'h7C22192D;
    idx = 0; first = -1;
    instHold = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 2) drive(cmds[cyc], 1); else cmdValid = 0;
      tick();
      if (instValid === 1'b1) begin
        if (first < 0) first = cyc;
        if (idx < 3) begin
          total++; if (instData !== exp[idx]) begin bad++; $display("[TB] FAIL sync_word%0d: got %h want %h", idx, instData, exp[idx]); end
          total++; if (cyc != first + idx) begin bad++; $display("[TB] FAIL sync_gap%0d: got cycle %0d want %0d", idx, cyc, first + idx); end
        end
        idx++;
      end
    end
    total++; if (idx != 3) begin bad++; $display("[TB] FAIL sync_count: got %0d want 3", idx); end
  endtask
`endif

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      total++; if (cmdReady !== (mq.size() < DEPTH)) begin bad++; $display("[TB] FAIL rnd_ready@%0d: got %b want %b", cyc, cmdReady, (mq.size() < DEPTH)); end
      total++; if (instValid !== m_valid) begin bad++; $display("[TB] FAIL rnd_valid@%0d: got %b want %b", cyc, instValid, m_valid); end
      total++; if (instErr !== m_err) begin bad++; $display("[TB] FAIL rnd_err@%0d: got %b want %b", cyc, instErr, m_err); end
      total++; if (busy !== (mq.size() > 0 || m_valid)) begin bad++; $display("[TB] FAIL rnd_busy@%0d: got %b want %b", cyc, busy, (mq.size() > 0 || m_valid)); end
      if (m_valid) begin
        total++; if (instData !== m_word) begin bad++; $display("[TB] FAIL rnd_data@%0d: got %h want %h", cyc, instData, m_word); end
      end
      drive(mk($urandom_range(0, 19), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom),
            ($urandom_range(0, 9) < 7));
      instHold = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 99) < 3);
      tick();
    end
    cmdValid = 0; instHold = 0; flush = 0;
    repeat (8) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rnd_idle: got %b want 0", busy); end
  endtask

  initial begin
    resetN = 0; cmdValid = 0; flush = 0; instHold = 0;
    drive(mk(0, 0, 0, 0, 0, 0, 0), 0);
    model_reset();
    test_reset();
    test_mtspr_latency();
    test_back_to_back();
    test_fill_hold();
    test_illegal();
    test_flush();
    test_async_reset();
`ifdef P405S_DCD_ENC_AUTOSYNC_EN
    test_autosync();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
